alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_if.sv | 44 ++++
 rtl/alu.sv | 122 ++++++++++++
 tb/tb_alu.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ALU operand/result bundle: operands and opcode in, registered result and flags out.
// Latency: none (wires only); the 1-cycle latency lives in the alu module.
// Backpressure: none; the ALU accepts a new operation on every clock edge.
//
// Signals:
//   a, b    : WIDTH-bit operands (unsigned / two's complement)
//   ALU_OP  : 3-bit operation select
//   result  : WIDTH-bit registered result
//   Z, C, N : registered zero, carry/borrow and negative flags
//
// Modports:
//   master : the side that drives operands and observes results
//   slave  : the ALU itself
interface alu_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALU_OP;
    logic [WIDTH-1:0] result;
    logic             Z;
    logic             C;
    logic             N;

    modport master (
        output a,
        output b,
        output ALU_OP,
        input  result,
        input  Z,
        input  C,
        input  N
    );

    modport slave (
        input  a,
        input  b,
        input  ALU_OP,
        output result,
        output Z,
        output C,
        output N
    );
endinterface

// File: rtl/alu.sv
// Registered ALU: add/sub/and/or/xor/not/shl1/shr1 with zero, carry/borrow and negative flags.
// Latency: 1 cycle from operands/opcode sampled at a rising clk edge to result and flags.
// Backpressure: none; an operation is accepted every cycle, no valid or enable.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (result=0, Z=1, C=0, N=0)
//   bus   : alu_if slave modport (a, b, ALU_OP in; result, Z, C, N out)
module alu #(
    parameter int         WIDTH      = 24,
    parameter logic [2:0] ALU_OP_ADD = 3'b000,
    parameter logic [2:0] ALU_OP_SUB = 3'b001,
    parameter logic [2:0] ALU_OP_AND = 3'b010,
    parameter logic [2:0] ALU_OP_OR  = 3'b011,
    parameter logic [2:0] ALU_OP_XOR = 3'b100,
    parameter logic [2:0] ALU_OP_NOT = 3'b101,
    parameter logic [2:0] ALU_OP_SHL = 3'b110,
    parameter logic [2:0] ALU_OP_SHR = 3'b111
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    // ------------------------------------------------------------------
    // Adder path shared by ADD and SUB.
    // One extra bit on top captures the carry out of bit WIDTH-1.
    // SUB is a + ~b + 1; its carry out is 1 when no borrow occurred, so
    // the borrow flag is the inverted carry (C=1 iff a < b unsigned).
    // ------------------------------------------------------------------
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;

    assign add_ext = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Operation select (combinational next result / carry).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] res_nxt;
    logic             c_nxt;

    always_comb begin
        res_nxt = '0;
        c_nxt   = 1'b0;
        case (bus.ALU_OP)
            ALU_OP_ADD: begin
                res_nxt = add_ext[WIDTH-1:0];
                c_nxt   = add_ext[WIDTH];
            end
            ALU_OP_SUB: begin
                res_nxt = sub_ext[WIDTH-1:0];
                c_nxt   = ~sub_ext[WIDTH];
            end
            ALU_OP_AND: begin
                res_nxt = bus.a & bus.b;
            end
            ALU_OP_OR: begin
                res_nxt = bus.a | bus.b;
            end
            ALU_OP_XOR: begin
                res_nxt = bus.a ^ bus.b;
            end
            ALU_OP_NOT: begin
                res_nxt = ~bus.a;
            end
            ALU_OP_SHL: begin
                // The bit shifted out of the top lands in C.
                res_nxt = {bus.a[WIDTH-2:0], 1'b0};
                c_nxt   = bus.a[WIDTH-1];
            end
            ALU_OP_SHR: begin
                // The bit shifted out of the bottom lands in C.
                res_nxt = {1'b0, bus.a[WIDTH-1:1]};
                c_nxt   = bus.a[0];
            end
            default: begin
                // All eight opcode encodings are listed above; nothing
                // reaches here with the default parameter set.
                res_nxt = '0;
                c_nxt   = 1'b0;
            end
        endcase
    end

    // Z and N derive from the value about to be registered, so the flags
    // always agree with the registered result in the same cycle.
    logic z_nxt;
    logic n_nxt;

    assign z_nxt = (res_nxt == '0);
    assign n_nxt = res_nxt[WIDTH-1];

    // ------------------------------------------------------------------
    // Output registers. Reset wins over any operation at the same edge,
    // discarding whatever was sampled there.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_q;
    logic             z_q;
    logic             c_q;
    logic             n_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            z_q      <= 1'b1;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            result_q <= res_nxt;
            z_q      <= z_nxt;
            c_q      <= c_nxt;
            n_q      <= n_nxt;
        end
    end

    assign bus.result = result_q;
    assign bus.Z      = z_q;
    assign bus.C      = c_q;
    assign bus.N      = n_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors, one cycle per step.
// Latency: each step drives on the falling edge and checks #1 after the next rising edge.
// Backpressure: none to model; the DUT accepts every cycle.
module tb_alu;

    localparam int WIDTH = 24;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation, let one rising edge register it, then compare.
    task automatic step(input string tag, input logic rn, input logic [2:0] op,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] er, input logic ez,
                        input logic ec, input logic en);
        @(negedge clk);
        rst_n      = rn;
        bus.ALU_OP = op;
        bus.a      = av;
        bus.b      = bv;
        @(posedge clk);
        #1;
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".Z"}, {{(WIDTH-1){1'b0}}, bus.Z}, {{(WIDTH-1){1'b0}}, ez});
        chk({tag, ".C"}, {{(WIDTH-1){1'b0}}, bus.C}, {{(WIDTH-1){1'b0}}, ec});
        chk({tag, ".N"}, {{(WIDTH-1){1'b0}}, bus.N}, {{(WIDTH-1){1'b0}}, en});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.ALU_OP = OP_ADD;
        bus.a      = '0;
        bus.b      = '0;

        // Reset state, with an ADD presented that must be discarded.
        step("reset",      1'b0, OP_ADD, 24'd500,    24'd500,    24'h000000, 1'b1, 1'b0, 1'b0);

        // Arithmetic.
        step("add_500",    1'b1, OP_ADD, 24'd500,    24'd500,    24'd1000,   1'b0, 1'b0, 1'b0);
        step("sub_eq",     1'b1, OP_SUB, 24'd100,    24'd100,    24'h000000, 1'b1, 1'b0, 1'b0);
        step("sub_neg",    1'b1, OP_SUB, 24'd100,    24'd400,    24'hFFFED4, 1'b0, 1'b1, 1'b1);
        step("sub_pos",    1'b1, OP_SUB, 24'd400,    24'd100,    24'h00012C, 1'b0, 1'b0, 1'b0);
        step("add_wrap",   1'b1, OP_ADD, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b1, 1'b0);
        step("sub_0m1",    1'b1, OP_SUB, 24'h000000, 24'h000001, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);
        step("add_neg",    1'b1, OP_ADD, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b1);

        // Bitwise.
        step("and",        1'b1, OP_AND, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0, 1'b0, 1'b1);
        step("or",         1'b1, OP_OR,  24'h0F0F0F, 24'hF00000, 24'hFF0F0F, 1'b0, 1'b0, 1'b1);
        step("xor_zero",   1'b1, OP_XOR, 24'h123456, 24'h123456, 24'h000000, 1'b1, 1'b0, 1'b0);
        step("xor",        1'b1, OP_XOR, 24'h00FF00, 24'h0F0F0F, 24'h0FF00F, 1'b0, 1'b0, 1'b0);
        step("not",        1'b1, OP_NOT, 24'h000000, 24'h123456, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        step("not_ff",     1'b1, OP_NOT, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0);

        // Shifts by one, b ignored.
        step("shl",        1'b1, OP_SHL, 24'h800001, 24'hABCDEF, 24'h000002, 1'b0, 1'b1, 1'b0);
        step("shr",        1'b1, OP_SHR, 24'h000003, 24'hABCDEF, 24'h000001, 1'b0, 1'b1, 1'b0);
        step("shl_n",      1'b1, OP_SHL, 24'h400000, 24'h000000, 24'h800000, 1'b0, 1'b0, 1'b1);
        step("shr_z",      1'b1, OP_SHR, 24'h000001, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0);
        step("shr_msb",    1'b1, OP_SHR, 24'h800000, 24'h000000, 24'h400000, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset discards the operation; the next edge is normal.
        step("midrst",     1'b0, OP_ADD, 24'd500,    24'd500,    24'h000000, 1'b1, 1'b0, 1'b0);
        step("after_rst",  1'b1, OP_ADD, 24'd500,    24'd500,    24'd1000,   1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
